// File: rtl/ram_responder.sv
// Word-addressed RAM model serving the memory controller's RAM request port.
// Requests are level-held; each new request waits LAT cycles in BUSY, then commits once on entering ACCESS.
module ram_responder #(
    parameter int LAT   = 2,
    parameter int WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    ramstate_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ren_q, wen_q;
    logic [31:0]    addr_q, data_q;
    logic [31:0]    ramload_q;
    logic [31:0]    mem [WORDS];

    logic           req, illegal, same_key, latch, commit;
    logic           c_wen;
    logic [IW-1:0]  c_idx;
    logic [31:0]    c_data;

    assign req      = ramREN | ramWEN;
    assign illegal  = (ramREN & ramWEN) || (ramaddr[1:0] != 2'b00) ||
                      ({2'b00, ramaddr[31:2]} >= 32'(WORDS));
    // Store data only distinguishes writes; a read's ramstore is don't-care.
    assign same_key = (ramREN == ren_q) && (ramWEN == wen_q) && (ramaddr == addr_q) &&
                      (!ramWEN || (ramstore == data_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        if (!req) begin
            state_d = FREE;
        end else if (illegal) begin
            state_d = ERROR;
        end else if (!same_key || state_q == FREE || state_q == ERROR) begin
            latch = 1'b1;
            if (LAT == 0) begin
                state_d = ACCESS;
                commit  = 1'b1;
            end else begin
                state_d = BUSY;
                cnt_d   = CW'(LAT - 1);
            end
        end else if (state_q == BUSY) begin
            if (cnt_q == '0) begin
                state_d = ACCESS;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // With LAT==0 the commit happens on the latching edge, so take the live request.
    assign c_wen  = latch ? ramWEN : wen_q;
    assign c_idx  = latch ? ramaddr[IW+1:2] : addr_q[IW+1:2];
    assign c_data = latch ? ramstore : data_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ramload_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                ren_q  <= ramREN;
                wen_q  <= ramWEN;
                addr_q <= ramaddr;
                data_q <= ramstore;
            end
            if (commit) begin
                if (c_wen) mem[c_idx] <= c_data;
                else       ramload_q  <= mem[c_idx];
            end
        end
    end

    assign ramstate = state_q;
    assign ramload  = ramload_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: an age-based request model checked every cycle, plus literal spot checks.
module tb_ram_responder;
    localparam int LAT   = 2;
    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_ren, a_wen, b_ren, b_wen;
    logic [31:0] a_addr, a_data, b_addr, b_data;
    logic [31:0] a_load, b_load;
    logic [1:0]  a_state, b_state;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_responder #(.LAT(LAT), .WORDS(WORDS)) dut (
        .CLK(clk), .RST(rst), .ramREN(a_ren), .ramWEN(a_wen), .ramaddr(a_addr),
        .ramstore(a_data), .ramload(a_load), .ramstate(a_state)
    );

    ram_responder #(.LAT(0), .WORDS(1024)) dut0 (
        .CLK(clk), .RST(rst), .ramREN(b_ren), .ramWEN(b_wen), .ramaddr(b_addr),
        .ramstore(b_data), .ramload(b_load), .ramstate(b_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request's age counts edges since it was first seen; BUSY until age==LAT.
    logic [31:0] m_mem [WORDS];
    logic [1:0]  m_state = 2'd0;
    logic [31:0] m_load = '0;
    logic        m_ren = 1'b0, m_wen = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0;
    int          m_age = 0;

    always @(posedge clk or posedge rst) begin : model
        logic ill, same;
        if (rst) begin
            m_state = 2'd0; m_load = '0; m_age = 0;
            m_ren = 1'b0; m_wen = 1'b0; m_addr = '0; m_data = '0;
        end else if (!(a_ren || a_wen)) begin
            m_state = 2'd0;
        end else begin
            ill = (a_ren && a_wen) || (a_addr % 4 != 0) || (a_addr / 4 >= WORDS);
            if (ill) begin
                m_state = 2'd3;
            end else begin
                same = (a_ren == m_ren) && (a_wen == m_wen) && (a_addr == m_addr) &&
                       (!a_wen || a_data == m_data);
                if (!same || m_state == 2'd0 || m_state == 2'd3) begin
                    m_ren = a_ren; m_wen = a_wen; m_addr = a_addr; m_data = a_data;
                    m_age = 0;
                end else if (m_age <= LAT) begin
                    m_age++;
                end
                if (m_age < LAT) m_state = 2'd1;
                else begin
                    m_state = 2'd2;
                    if (m_age == LAT) begin
                        if (m_wen) m_mem[m_addr / 4] = m_data;
                        else       m_load = m_mem[m_addr / 4];
                        m_age++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("model.ramstate", {30'd0, a_state}, {30'd0, m_state});
            chk("model.ramload", a_load, m_load);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        a_ren = r; a_wen = w; a_addr = a; a_data = d;
    endtask

    // Full write or read transaction on the LAT=2 instance, then one idle cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        drv(!w, w, a, d);
        repeat (LAT + 1) cyc();
        chk("xfer.access", {30'd0, a_state}, 32'd2);
        drv(0, 0, 0, 0);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        rst = 1'b1;
        drv(0, 0, 0, 0);
        b_ren = 0; b_wen = 0; b_addr = 0; b_data = 0;
        cyc(); cyc();
        chk("reset.state", {30'd0, a_state}, 32'd0);
        chk("reset.load", a_load, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc();

        // write then read at LAT=2
        drv(0, 1, 32'h40, 32'hDEADBEEF);
        cyc(); chk("wr.busy1", {30'd0, a_state}, 32'd1);
        cyc(); chk("wr.busy2", {30'd0, a_state}, 32'd1);
        cyc(); chk("wr.access", {30'd0, a_state}, 32'd2);
        drv(1, 0, 32'h40, 32'h0);
        cyc(); chk("rd.busy1", {30'd0, a_state}, 32'd1);
        cyc(); chk("rd.busy2", {30'd0, a_state}, 32'd1);
        cyc(); chk("rd.access", {30'd0, a_state}, 32'd2);
        chk("rd.data", a_load, 32'hDEADBEEF);
        cyc(); chk("rd.hold", {30'd0, a_state}, 32'd2);
        drv(0, 0, 0, 0);
        cyc(); chk("idle.free", {30'd0, a_state}, 32'd0);

        xfer(1, 32'h10, 32'h11111111);
        xfer(1, 32'h20, 32'h22222222);
        xfer(1, 32'h08, 32'h00000000);

        // address change mid-BUSY restarts latency
        drv(1, 0, 32'h10, 0);
        cyc(); chk("chg.busy0", {30'd0, a_state}, 32'd1);
        drv(1, 0, 32'h20, 0);
        cyc(); chk("chg.busy1", {30'd0, a_state}, 32'd1);
        cyc(); chk("chg.busy2", {30'd0, a_state}, 32'd1);
        cyc(); chk("chg.access", {30'd0, a_state}, 32'd2);
        chk("chg.data", a_load, 32'h22222222);
        drv(0, 0, 0, 0); cyc();

        // aborted write never lands
        drv(0, 1, 32'h08, 32'h5);
        cyc(); chk("abort.busy", {30'd0, a_state}, 32'd1);
        drv(0, 0, 0, 0);
        cyc(); chk("abort.free", {30'd0, a_state}, 32'd0);
        xfer(0, 32'h08, 0);
        chk("abort.data", a_load, 32'h0);

        // illegal requests
        drv(1, 1, 32'h40, 32'h0);
        cyc(); chk("ill.both", {30'd0, a_state}, 32'd3);
        cyc(); chk("ill.hold", {30'd0, a_state}, 32'd3);
        drv(1, 0, 32'h2, 0);
        cyc(); chk("ill.align", {30'd0, a_state}, 32'd3);
        drv(0, 1, 32'(4 * WORDS), 32'h77);
        cyc(); chk("ill.range", {30'd0, a_state}, 32'd3);
        drv(1, 0, 32'h40, 0);
        cyc(); chk("ill.recover", {30'd0, a_state}, 32'd1);
        cyc(); cyc(); chk("ill.memkept", a_load, 32'hDEADBEEF);
        drv(0, 0, 0, 0); cyc();

        // top legal word
        xfer(1, 32'(4 * (WORDS - 1)), 32'hA5A5A5A5);
        xfer(0, 32'(4 * (WORDS - 1)), 0);
        chk("top.data", a_load, 32'hA5A5A5A5);

        // LAT=0 instance
        b_ren = 0; b_wen = 1; b_addr = 32'h40; b_data = 32'hCAFEF00D;
        cyc(); chk("lat0.wr", {30'd0, b_state}, 32'd2);
        b_ren = 1; b_wen = 0;
        cyc(); chk("lat0.rd", {30'd0, b_state}, 32'd2);
        chk("lat0.data", b_load, 32'hCAFEF00D);
        cyc(); chk("lat0.hold", {30'd0, b_state}, 32'd2);
        b_ren = 0;
        cyc(); chk("lat0.free", {30'd0, b_state}, 32'd0);

        // async reset mid-BUSY
        drv(0, 1, 32'h40, 32'h12345678);
        cyc(); chk("rst.busy", {30'd0, a_state}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst.state", {30'd0, a_state}, 32'd0);
        chk("rst.load", a_load, 32'h0);
        drv(0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        cyc();
        xfer(0, 32'h40, 0);
        chk("rst.nowrite", a_load, 32'hDEADBEEF);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
